// File: rtl/slos_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : slos_gen_multi
// Purpose  : Multi-lane SLOS1/SLOS2 ordered-set generator for USB4 logical
//            layer lane training. Each lane runs its own PRBS11 LFSR
//            (x^11 + x^9 + 1) from a per-lane seed and emits DATA_W bits per
//            cycle. A round is 2048 bits per lane: the seed state is used
//            twice, followed by the next 2046 LFSR states. SLOS2 is the bitwise
//            inverse of SLOS1.
//
// Parameters:
//   LANES   - number of lanes (1..4)
//   DATA_W  - bits per lane per cycle (1, 2, 4, 8, 16 or 32)
//   SEEDS   - LANES*11 packed seeds, lane i uses SEEDS[11*i +: 11]; nonzero
//   RND_W   - width of the round-count input and counters
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous, active-low reset
//   start       in   one-cycle request to begin; ignored while busy
//   slos_mode   in   0 = SLOS1, 1 = SLOS2; latched at start
//   num_rounds  in   rounds to send, 0 = until stop; latched at start
//   stop        in   finish the current round, then end (sticky)
//   ready       in   downstream accepts the current word
//   data_out    out  lane i in [i*DATA_W +: DATA_W], bit 0 earliest
//   valid_out   out  data_out holds a valid word
//   busy        out  high while a sequence is running
//   round_done  out  pulse on acceptance of the last word of a round
//   done        out  one-cycle pulse when the sequence ends
//   rounds_sent out  completed rounds, saturating
//
// Optional feature (macro SLOS_ERR_INJECT_EN):
//   err_inject  in   invert bit 0 of lane 0 of the word accepted this cycle
//   err_count   out  saturating count of injections, cleared at start
//
// Revision : 1.0  initial multi-lane release
// ============================================================================
module slos_gen_multi #(
  parameter int                   LANES  = 2,
  parameter int                   DATA_W = 8,
  parameter logic [LANES*11-1:0]  SEEDS  = {11'h0a3, 11'h400},
  parameter int                   RND_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef SLOS_ERR_INJECT_EN
  input  logic                      err_inject,
  output logic [RND_W-1:0]          err_count,
`endif
  input  logic                      start,
  input  logic                      slos_mode,
  input  logic [RND_W-1:0]          num_rounds,
  input  logic                      stop,
  input  logic                      ready,
  output logic [LANES*DATA_W-1:0]   data_out,
  output logic                      valid_out,
  output logic                      busy,
  output logic                      round_done,
  output logic                      done,
  output logic [RND_W-1:0]          rounds_sent
);

  localparam int               DW_TOT    = LANES * DATA_W;
  localparam int               WORDS     = 2048 / DATA_W;
  localparam logic [10:0]      LAST_WORD = 11'(WORDS - 1);
  localparam logic [RND_W:0]   ONE_EXT   = (RND_W + 1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic              r_mode;
  logic [RND_W-1:0]  r_num_rounds;
  logic              r_stop_seen;
  logic [10:0]       r_word_idx;

  logic              w_run;
  logic              w_accept;
  logic              w_first_word;
  logic              w_last_word;
  logic              w_stop_any;
  logic              w_final_round;
  logic              w_take_start;
  logic [RND_W:0]    w_rounds_inc;
  logic [DW_TOT-1:0] w_word_all;
  logic [DW_TOT-1:0] w_inj_mask;
  logic              w_inj;

  assign w_run        = (r_state == S_RUN);
  assign w_accept     = w_run & ready;
  assign w_first_word = (r_word_idx == 11'd0);
  assign w_last_word  = (r_word_idx == LAST_WORD);
  assign w_take_start = (r_state == S_IDLE) & start;

  // A stop arriving in the same cycle as the last word of a round still ends
  // the sequence at that round boundary.
  assign w_stop_any   = r_stop_seen | stop;

  // Widened by one bit so the comparison against num_rounds cannot wrap.
  assign w_rounds_inc = {1'b0, rounds_sent} + ONE_EXT;

  assign w_final_round = ((r_num_rounds != '0) &&
                          (w_rounds_inc == {1'b0, r_num_rounds})) ||
                         w_stop_any;

  // --------------------------------------------------------------------------
  // Per-lane PRBS11 generators
  // --------------------------------------------------------------------------
  // r_lfsr holds the LFSR state for the first bit of the current word. The
  // first word of a round reuses the seed for its second bit, so the very
  // first step of the unrolled chain is skipped there.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      localparam logic [10:0] SEED = SEEDS[11*gi +: 11];

      logic [10:0]       r_lfsr;
      logic [10:0]       w_lfsr_next;
      logic [DATA_W-1:0] w_bits;

      always_comb begin : p_unroll
        logic [10:0] st;
        st     = r_lfsr;
        w_bits = '0;
        for (int j = 0; j < DATA_W; j++) begin
          w_bits[j] = st[0] ^ r_mode;
          if (!(w_first_word && (j == 0))) begin
            st = {st[9:0], st[10] ^ st[8]};
          end
        end
        w_lfsr_next = st;
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          r_lfsr <= SEED;
        end else if (w_take_start) begin
          r_lfsr <= SEED;
        end else if (w_accept) begin
          // Every round restarts from the seed, duplicate included.
          r_lfsr <= w_last_word ? SEED : w_lfsr_next;
        end
      end

      assign w_word_all[gi*DATA_W +: DATA_W] = w_bits;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_num_rounds <= '0;
      r_stop_seen  <= 1'b0;
      r_word_idx   <= 11'd0;
      rounds_sent  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_RUN;
            r_mode       <= slos_mode;
            r_num_rounds <= num_rounds;
            // A stop presented together with start limits the run to one round.
            r_stop_seen  <= stop;
            r_word_idx   <= 11'd0;
            rounds_sent  <= '0;
          end
        end

        S_RUN: begin
          if (stop) begin
            r_stop_seen <= 1'b1;
          end
          if (w_accept) begin
            if (w_last_word) begin
              r_word_idx <= 11'd0;
              if (rounds_sent != '1) begin
                rounds_sent <= w_rounds_inc[RND_W-1:0];
              end
              if (w_final_round) begin
                r_state <= S_FIN;
              end
            end else begin
              r_word_idx <= r_word_idx + 11'd1;
            end
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Optional error injection
  // --------------------------------------------------------------------------
`ifdef SLOS_ERR_INJECT_EN
  // Only the output word is corrupted; the LFSRs advance normally.
  assign w_inj = w_accept & err_inject;

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_count <= '0;
    end else if (w_take_start) begin
      err_count <= '0;
    end else if (w_inj && (err_count != '1)) begin
      err_count <= err_count + RND_W'(1);
    end
  end
`else
  assign w_inj = 1'b0;
`endif

  always_comb begin
    w_inj_mask    = '0;
    w_inj_mask[0] = w_inj;
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign data_out   = w_run ? (w_word_all ^ w_inj_mask) : '0;
  assign valid_out  = w_run;
  assign busy       = w_run;
  assign round_done = w_accept & w_last_word;
  assign done       = (r_state == S_FIN);

endmodule
`default_nettype wire

// File: tb/tb_slos_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_slos_gen_multi
// Purpose  : Self-checking bench for slos_gen_multi. Three instances:
//            A (2 lanes x 8 bits, default seeds), B (1 lane x 1 bit, seed
//            11'h400) and C (2 lanes x 4 bits, default seeds). Expected words
//            come from a bit-serial PRBS11 reference plus hand-computed words.
// Revision : 1.0  initial release
// ============================================================================
module tb_slos_gen_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_i, mode_i, stop_i, ready_i;
  logic [7:0] nr_i;
  int         sel;

  logic start_a, start_b, start_c;
  assign start_a = start_i && (sel == 0);
  assign start_b = start_i && (sel == 1);
  assign start_c = start_i && (sel == 2);

  logic [15:0] data_a;  logic valid_a, busy_a, rd_a, done_a;  logic [7:0] rs_a;
  logic        data_b;  logic valid_b, busy_b, rd_b, done_b;  logic [7:0] rs_b;
  logic [7:0]  data_c;  logic valid_c, busy_c, rd_c, done_c;  logic [7:0] rs_c;
`ifdef SLOS_ERR_INJECT_EN
  logic [7:0] ec_a, ec_b, ec_c;
`endif

  slos_gen_multi u_a (
    .clk(clk), .reset(reset),
`ifdef SLOS_ERR_INJECT_EN
    .err_inject(1'b0), .err_count(ec_a),
`endif
    .start(start_a), .slos_mode(mode_i), .num_rounds(nr_i), .stop(stop_i),
    .ready(ready_i), .data_out(data_a), .valid_out(valid_a), .busy(busy_a),
    .round_done(rd_a), .done(done_a), .rounds_sent(rs_a)
  );

  slos_gen_multi #(.LANES(1), .DATA_W(1), .SEEDS(11'h400)) u_b (
    .clk(clk), .reset(reset),
`ifdef SLOS_ERR_INJECT_EN
    .err_inject(1'b0), .err_count(ec_b),
`endif
    .start(start_b), .slos_mode(mode_i), .num_rounds(nr_i), .stop(stop_i),
    .ready(ready_i), .data_out(data_b), .valid_out(valid_b), .busy(busy_b),
    .round_done(rd_b), .done(done_b), .rounds_sent(rs_b)
  );

  slos_gen_multi #(.LANES(2), .DATA_W(4)) u_c (
    .clk(clk), .reset(reset),
`ifdef SLOS_ERR_INJECT_EN
    .err_inject(1'b0), .err_count(ec_c),
`endif
    .start(start_c), .slos_mode(mode_i), .num_rounds(nr_i), .stop(stop_i),
    .ready(ready_i), .data_out(data_c), .valid_out(valid_c), .busy(busy_c),
    .round_done(rd_c), .done(done_c), .rounds_sent(rs_c)
  );

  // Selected-instance view
  logic [15:0] s_data;
  logic        s_valid, s_busy, s_rd, s_done;
  logic [7:0]  s_rs;
  always_comb begin
    s_data = '0; s_valid = 1'b0; s_busy = 1'b0; s_rd = 1'b0; s_done = 1'b0; s_rs = '0;
    case (sel)
      0: begin s_data = data_a; s_valid = valid_a; s_busy = busy_a; s_rd = rd_a; s_done = done_a; s_rs = rs_a; end
      1: begin s_data = {15'd0, data_b}; s_valid = valid_b; s_busy = busy_b; s_rd = rd_b; s_done = done_b; s_rs = rs_b; end
      default: begin s_data = {8'd0, data_c}; s_valid = valid_c; s_busy = busy_c; s_rd = rd_c; s_done = done_c; s_rs = rs_c; end
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Bit-serial reference: bit 0 and bit 1 from the seed, then one step per bit.
  bit ref_400 [0:2047];
  bit ref_0a3 [0:2047];

  function automatic logic [10:0] prbs_step(input logic [10:0] s);
    return {s[9:0], s[10] ^ s[8]};
  endfunction

  function automatic logic [15:0] exp_word(input int which, input int acc, input bit mode);
    int dw, lanes, p;
    logic [15:0] w;
    bit b;
    dw    = (which == 0) ? 8 : (which == 1) ? 1 : 4;
    lanes = (which == 1) ? 1 : 2;
    p     = (acc % (2048 / dw)) * dw;
    w     = '0;
    for (int l = 0; l < lanes; l++) begin
      for (int k = 0; k < dw; k++) begin
        b = (l == 0) ? ref_400[p + k] : ref_0a3[p + k];
        w[l*dw + k] = b ^ mode;
      end
    end
    return w;
  endfunction

  logic [2047:0] cap, cap_save;
  logic [15:0]   first_word;

  task automatic run_sel(input int which, input bit mode, input int nr, input bit stop_now,
                         input int stop_at, input bit rnd_ready, input int exp_words,
                         input int exp_rounds, input string tag);
    int acc, errs, rd_errs, hold_errs, cyc, last_acc_cyc, done_gap, wpr;
    bit got_done, held, busy_at_done, valid_at_done;
    logic [15:0] held_data;
    logic [7:0]  rs_at_done;
    wpr = (which == 0) ? 256 : (which == 1) ? 2048 : 512;
    sel = which;
    @(negedge clk);
    start_i = 1'b1; mode_i = mode; nr_i = 8'(nr); stop_i = stop_now; ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; stop_i = 1'b0; mode_i = ~mode; nr_i = 8'(nr + 5);
    #1;
    check_eq({tag, ":busy_after_start"},  32'(s_busy),  32'd1);
    check_eq({tag, ":valid_after_start"}, 32'(s_valid), 32'd1);
    check_eq({tag, ":rounds_cleared"},    32'(s_rs),    32'd0);
    acc = 0; errs = 0; rd_errs = 0; hold_errs = 0; cyc = 0; last_acc_cyc = -10;
    done_gap = -1; got_done = 1'b0; held = 1'b0; held_data = '0;
    busy_at_done = 1'b1; valid_at_done = 1'b1; rs_at_done = '0;
    while (!got_done && (cyc < 20000)) begin
      ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stop_i  = (acc == stop_at);
      start_i = (acc == 40);
      #1;
      if (held && (s_data !== held_data)) hold_errs++;
      held = 1'b0;
      if (s_done) begin
        got_done      = 1'b1;
        done_gap      = cyc - last_acc_cyc;
        busy_at_done  = s_busy;
        valid_at_done = s_valid;
        rs_at_done    = s_rs;
      end else if (s_valid) begin
        if (s_data !== exp_word(which, acc, mode)) errs++;
        if (ready_i) begin
          if (s_rd !== ((acc % wpr) == (wpr - 1))) rd_errs++;
          if (acc < 2048) cap[acc] = s_data[0];
          if (acc == 0) first_word = s_data;
          acc++;
          last_acc_cyc = cyc;
        end else begin
          if (s_rd) rd_errs++;
          held = 1'b1;
          held_data = s_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0; stop_i = 1'b0; ready_i = 1'b1;
    check_eq({tag, ":done_seen"},     32'(got_done),      32'd1);
    check_eq({tag, ":words"},         32'(acc),           32'(exp_words));
    check_eq({tag, ":data_errs"},     32'(errs),          32'd0);
    check_eq({tag, ":round_done"},    32'(rd_errs),       32'd0);
    check_eq({tag, ":hold_errs"},     32'(hold_errs),     32'd0);
    check_eq({tag, ":done_latency"},  32'(done_gap),      32'd1);
    check_eq({tag, ":busy_at_done"},  32'(busy_at_done),  32'd0);
    check_eq({tag, ":valid_at_done"}, 32'(valid_at_done), 32'd0);
    check_eq({tag, ":rounds_sent"},   32'(rs_at_done),    32'(exp_rounds));
    #1;
    check_eq({tag, ":done_pulse"},    32'(s_done),        32'd0);
    check_eq({tag, ":rounds_hold"},   32'(s_rs),          32'(exp_rounds));
  endtask

  initial begin : p_main
    logic [10:0] s;
    int d;
    s = 11'h400; ref_400[0] = s[0]; ref_400[1] = s[0];
    for (int p = 2; p < 2048; p++) begin s = prbs_step(s); ref_400[p] = s[0]; end
    s = 11'h0a3; ref_0a3[0] = s[0]; ref_0a3[1] = s[0];
    for (int p = 2; p < 2048; p++) begin s = prbs_step(s); ref_0a3[p] = s[0]; end

    sel = 0; start_i = 1'b0; mode_i = 1'b0; stop_i = 1'b0; ready_i = 1'b1; nr_i = '0;
    cap = '0; cap_save = '0; first_word = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst:valid_a", 32'(valid_a), 32'd0);
    check_eq("rst:busy_a",  32'(busy_a),  32'd0);
    check_eq("rst:done_a",  32'(done_a),  32'd0);
    check_eq("rst:data_a",  32'(data_a),  32'd0);
    check_eq("rst:rs_a",    32'(rs_a),    32'd0);
    check_eq("rst:valid_b", 32'(valid_b), 32'd0);
    check_eq("rst:valid_c", 32'(valid_c), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single-lane bit-serial, SLOS1 then SLOS2.
    run_sel(1, 1'b0, 1, 1'b0, -1, 1'b0, 2048, 1, "b_slos1");
    check_eq("b_slos1:first_bits", 32'(cap[4:0]), 32'b00100);
    cap_save = cap;
    run_sel(1, 1'b1, 1, 1'b0, -1, 1'b0, 2048, 1, "b_slos2");
    check_eq("b_slos2:first_bits", 32'(cap[4:0]), 32'b11011);
    d = 0;
    for (int i = 0; i < 2048; i++) if (cap[i] !== ~cap_save[i]) d++;
    check_eq("b_slos2:inverse_bits", 32'(d), 32'd0);

    // Two lanes x 8 bits, three rounds.
    run_sel(0, 1'b0, 3, 1'b0, -1, 1'b0, 768, 3, "a_three");
    check_eq("a_three:word0", 32'(first_word), 32'h8b04);

    // Continuous, stop during round 2 at word 100.
    run_sel(0, 1'b0, 0, 1'b0, 356, 1'b0, 512, 2, "a_stop");

    // Stop together with start -> exactly one round.
    run_sel(0, 1'b0, 0, 1'b1, -1, 1'b0, 256, 1, "a_stop_start");

    // Two lanes x 4 bits, SLOS2, random backpressure.
    run_sel(2, 1'b1, 1, 1'b0, -1, 1'b1, 512, 1, "c_bp");

    // Reset mid-run at word 37 of round 2, then a fresh run.
    sel = 0;
    @(negedge clk);
    start_i = 1'b1; mode_i = 1'b0; nr_i = 8'd0; ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (293) @(negedge clk);
    #1;
    check_eq("rstmid:word_before", 32'(data_a), 32'(exp_word(0, 293, 1'b0)));
    check_eq("rstmid:rs_before",   32'(rs_a),   32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("rstmid:valid", 32'(valid_a), 32'd0);
    check_eq("rstmid:busy",  32'(busy_a),  32'd0);
    check_eq("rstmid:data",  32'(data_a),  32'd0);
    check_eq("rstmid:rs",    32'(rs_a),    32'd0);
    check_eq("rstmid:rd",    32'(rd_a),    32'd0);
    check_eq("rstmid:done",  32'(done_a),  32'd0);
    run_sel(0, 1'b0, 1, 1'b0, -1, 1'b0, 256, 1, "a_after_rst");
    check_eq("a_after_rst:word0", 32'(first_word), 32'h8b04);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slos_gen_multi.md
Name: slos_gen_multi

Overview:
- Parametrised successor to the single-lane serial SLOS sender in the USB4 logical-layer training path.
- Generates SLOS1/SLOS2 ordered sets from a PRBS11 sequence (x^11 + x^9 + 1) for LANES lanes at once, each lane with its own seed, emitting DATA_W bits per lane per cycle.
- Adds a start/stop/done handshake, a programmable round count and downstream backpressure.
- Sits between the lane-initialisation FSM and the per-lane serializer/encoder.

Parameters:
- LANES, 2, number of lanes (1..4).
- DATA_W, 8, bits per lane per cycle; one of 1, 2, 4, 8, 16, 32 (divides 2048).
- SEEDS, {11'h0a3, 11'h400}, LANES*11-bit packed seeds; lane i uses SEEDS[11*i +: 11]; each seed nonzero.
- RND_W, 8, width of the round-count input and counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin; ignored while busy
- slos_mode  in  1  0=SLOS1, 1=SLOS2 (all bits inverted); latched at start
- num_rounds  in  RND_W  rounds to send; 0 = continuous until stop; latched at start
- stop  in  1  finish the current round, then end
- ready  in  1  downstream accepts the current word
- data_out  out  LANES*DATA_W  lane i in [i*DATA_W +: DATA_W]; bit 0 is the earliest bit
- valid_out  out  1  data_out holds a valid word
- busy  out  1  high from the cycle after start until done
- round_done  out  1  pulse on acceptance of the last word of a round
- done  out  1  one-cycle pulse when the sequence ends
- rounds_sent  out  RND_W  completed rounds; saturates at all-ones

Behaviour:
- Reset (reset=0 at a clk edge) takes priority over everything, including mid-run. It forces IDLE; all outputs 0; LFSRs = seeds; counters 0.
- Round definition: 2048 bits per lane.
  - LFSR state sequence: S0 = seed, S0 again (duplicate), then S1..S2046, where S(k+1) = {S(k)[9:0], S(k)[10]^S(k)[8]}.
  - Emitted bit = state[0], XOR slos_mode.
  - After bit 2047 the LFSR reloads the seed; the next round starts with the duplicate again.
- Word = DATA_W consecutive bits. 2048/DATA_W words per round. Word boundaries always align to the round start.
- FSM:
  - IDLE: valid_out=0. On start=1: latch mode and num_rounds, load seeds, bit position 0, go to RUN. busy=1 and valid_out=1 with word 0 on the next cycle (latency 1).
  - RUN: the word advances only when valid_out && ready; otherwise data_out and all state hold.
    - On an accepted last word: round_done=1 and rounds_sent increments.
    - If num_rounds!=0 and rounds_sent+1 == num_rounds: go to FIN.
    - Else if stop has been seen since start (sticky): go to FIN.
    - Else continue with the next round.
  - FIN: one cycle; done=1, busy=0, valid_out=0; then IDLE.
- stop is sticky. It never truncates a round. stop in IDLE is ignored. stop together with start: start is taken and the stop is registered, so exactly one round is sent.
- start while busy is ignored, with no restart.
- slos_mode and num_rounds changes during RUN have no effect.
- rounds_sent clears at start and holds its value in IDLE after done.
- ready=0 for any number of cycles causes no bit loss or duplication.

Optional Feature:
- Macro: SLOS_ERR_INJECT_EN.
- Defined:
  - Extra input err_inject (1 bit).
  - When err_inject=1 on a cycle where a word is accepted, bit 0 of lane 0 of that word is inverted on data_out.
  - LFSR state is unaffected; subsequent words are correct.
  - Output err_count (RND_W, saturating) counts injections and is cleared at start.
- Undefined: no err_inject or err_count ports; data_out is always the pure sequence.

Test Plan:
- LANES=1, DATA_W=1, SEED=11'h400, SLOS1, num_rounds=1, ready=1 -> bits 0,0,1,0,0,...; exactly 2048 valid cycles; round_done on the last; done the next cycle; rounds_sent=1.
- Same config with slos_mode=1 -> bits 1,1,0,1,1,...; each of the 2048 bits is the bitwise inverse of the SLOS1 run.
- LANES=2, DATA_W=8, default seeds, num_rounds=3 -> 768 valid words; both lanes match a bit-serial model per seed; round_done pulses at words 255, 511, 767; rounds_sent=3.
- num_rounds=0; assert stop at word 100 of round 2 -> round 2 completes (word 255); done one cycle later; rounds_sent=2.
- Random ready (about 50% low) with DATA_W=4 -> accepted stream identical to the ready=1 stream; data_out stable while ready=0.
- reset=0 at word 37, then start -> all outputs 0 in the cycle after reset; new run begins at bit 0 with the seed word; start during RUN has no effect.
